// File: rtl/img_bram_sequencer.sv
// img_bram_sequencer: arbitrates one BRAM port across UART load, processing and UART send phases
module img_bram_sequencer #(
  parameter int NPIX = 22500,
  parameter int AW = 15,
  parameter int DW = 8,
  parameter logic [23:0] TMO = 24'hFFFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          proc_start,
  input  logic          proc_en,
  input  logic          proc_we,
  input  logic [AW-1:0] proc_addr,
  input  logic [DW-1:0] proc_din,
  input  logic          proc_done,
  output logic          tx_start,
  input  logic          tx_en,
  input  logic [AW-1:0] tx_addr,
  input  logic          tx_done,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  output logic [2:0]    phase,
  output logic          show_i,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LOAD, PROC, SEND, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [AW-1:0] pix_cnt;
  logic [23:0] wd;
  logic entry, tmo, last_pix, ld, pr, sd;
  assign tmo = wd == TMO - 24'd1;
  assign last_pix = pix_cnt == AW'(NPIX - 1);
  assign ld = state == LOAD && rx_valid;
  assign pr = state == PROC;
  assign sd = state == SEND;
  // next state: watchdog beats a same-cycle done; done is ignored in the start-pulse cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, FAIL: state_n = start ? LOAD : state;
      LOAD: state_n = (rx_valid && last_pix) ? PROC : LOAD;
      PROC: state_n = tmo ? FAIL : (proc_done && !entry) ? SEND : PROC;
      SEND: state_n = tmo ? FAIL : (tx_done && !entry) ? DONE : SEND;
      default: state_n = IDLE;
    endcase
  end
  // state, entry flag, pixel counter and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      entry <= 1'b0;
      pix_cnt <= '0;
      wd <= '0;
    end else begin
      state <= state_n;
      entry <= state_n != state;
      pix_cnt <= (state_n == LOAD && state != LOAD) ? '0 :
                 (ld && !last_pix) ? pix_cnt + AW'(1) : pix_cnt;
      wd <= (state_n != state || !(pr || sd)) ? '0 : wd + 24'd1;
    end
  end
  assign phase = state;
  assign proc_start = pr && entry;
  assign tx_start = sd && entry;
  assign show_i = state == DONE;
  assign err = state == FAIL;
  assign bram_en = ld || (pr && proc_en) || (sd && tx_en);
  assign bram_we = ld || (pr && proc_we);
  assign bram_addr = ld ? pix_cnt : pr ? proc_addr : sd ? tx_addr : '0;
  assign bram_din = ld ? rx_data : pr ? proc_din : '0;
endmodule

// File: tb/tb_img_bram_sequencer.sv
// tb_img_bram_sequencer: randomized phase-by-phase check of the BRAM sequencer
module tb_img_bram_sequencer;
  localparam int NPIX = 4, AW = 15, DW = 8;
  localparam logic [23:0] TMO = 24'd20;
  logic clk = 0, reset = 1, start = 0, rx_valid = 0;
  logic [DW-1:0] rx_data = 0, proc_din = 0, bram_din;
  logic proc_start, proc_en = 0, proc_we = 0, proc_done = 0;
  logic [AW-1:0] proc_addr = 0, tx_addr = 0, bram_addr;
  logic tx_start, tx_en = 0, tx_done = 0, bram_en, bram_we, show_i, err;
  logic [2:0] phase;
  logic [DW-1:0] img [NPIX];
  int errs = 0, checks = 0;

  img_bram_sequencer #(.NPIX(NPIX), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .proc_start(proc_start), .proc_en(proc_en), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_din(proc_din), .proc_done(proc_done), .tx_start(tx_start), .tx_en(tx_en),
    .tx_addr(tx_addr), .tx_done(tx_done), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .phase(phase), .show_i(show_i), .err(err));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    start = 0; rx_valid = 0; proc_en = 0; proc_we = 0; proc_done = 0; tx_en = 0; tx_done = 0;
  endtask

  task automatic check_zero_port(input string name);
    #1;
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_din} !== '0) begin
      errs++;
      $display("FAIL %s: bram en=%b we=%b addr=%0d din=%h, want all 0", name, bram_en, bram_we, bram_addr, bram_din);
    end
  endtask

  task automatic do_start;
    start = 1;
    tick;
    start = 0;
    checks++;
    if (phase !== 3'd1 || err !== 0 || show_i !== 0) begin
      errs++;
      $display("FAIL start: phase=%0d err=%b show=%b, want 1/0/0", phase, err, show_i);
    end
  endtask

  // feeds NPIX random bytes with random idle gaps; ends in the first PROC cycle
  task automatic load_image;
    for (int i = 0; i < NPIX; i++) begin
      img[i] = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 0; rx_data = 8'($urandom);
        check_zero_port("load_gap");
        tick;
      end
      rx_valid = 1; rx_data = img[i];
      #1;
      checks++;
      if (bram_en !== 1 || bram_we !== 1 || bram_addr !== AW'(i) || bram_din !== img[i] || phase !== 3'd1) begin
        errs++;
        $display("FAIL load_write%0d: en=%b we=%b addr=%0d din=%h phase=%0d, want 1/1/%0d/%h/1",
                 i, bram_en, bram_we, bram_addr, bram_din, phase, i, img[i]);
      end
      tick;
    end
    rx_valid = 0;
    checks++;
    if (phase !== 3'd2 || proc_start !== 1) begin
      errs++;
      $display("FAIL load_to_proc: phase=%0d proc_start=%b, want 2/1", phase, proc_start);
    end
  endtask

  task automatic test_reset;
    quiet; reset = 1;
    tick; tick;
    reset = 0;
    checks++;
    if ({phase, proc_start, tx_start, show_i, err, bram_en, bram_we, bram_addr, bram_din} !== '0) begin
      errs++;
      $display("FAIL reset: phase=%0d ps=%b ts=%b show=%b err=%b en=%b addr=%0d, want all 0",
               phase, proc_start, tx_start, show_i, err, bram_en, bram_addr);
    end
    rx_valid = 1; rx_data = 8'h5A;
    check_zero_port("idle_rx_ignored");
    tick;
    rx_valid = 0;
    checks++;
    if (phase !== 3'd0) begin errs++; $display("FAIL idle_stays: phase=%0d want 0", phase); end
  endtask

  task automatic test_load;
    do_start;
    load_image;
  endtask

  task automatic test_ignored;
    proc_done = 1; start = 1;
    tick;
    proc_done = 0; start = 0;
    checks++;
    if (phase !== 3'd2 || proc_start !== 0) begin
      errs++;
      $display("FAIL proc_ignored: phase=%0d proc_start=%b, want 2/0", phase, proc_start);
    end
  endtask

  task automatic test_proc_mux;
    for (int k = 0; k < 6; k++) begin
      proc_en = (k == 0) ? 1'b1 : 1'($urandom);
      proc_we = (k == 0) ? 1'b1 : 1'($urandom);
      proc_addr = (k == 0) ? AW'(2) : AW'($urandom);
      proc_din = (k == 0) ? 8'hAA : 8'($urandom);
      rx_valid = 1'($urandom); rx_data = 8'($urandom);
      tx_en = 1; tx_addr = AW'($urandom);
      #1;
      checks++;
      if (bram_en !== proc_en || bram_we !== proc_we || bram_addr !== proc_addr || bram_din !== proc_din) begin
        errs++;
        $display("FAIL proc_mux%0d: en=%b we=%b addr=%0d din=%h, want %b/%b/%0d/%h",
                 k, bram_en, bram_we, bram_addr, bram_din, proc_en, proc_we, proc_addr, proc_din);
      end
      tick;
    end
    quiet;
  endtask

  task automatic test_send;
    proc_done = 1;
    tick;
    proc_done = 0;
    checks++;
    if (phase !== 3'd3 || tx_start !== 1) begin
      errs++;
      $display("FAIL send_entry: phase=%0d tx_start=%b, want 3/1", phase, tx_start);
    end
    tx_done = 1;
    for (int k = 0; k < 5; k++) begin
      tx_en = (k == 1) ? 1'b1 : 1'($urandom);
      tx_addr = (k == 1) ? AW'(3) : AW'($urandom);
      proc_en = 1; proc_we = 1; proc_din = 8'($urandom); rx_valid = 1;
      #1;
      checks++;
      if (bram_en !== tx_en || bram_we !== 0 || bram_addr !== tx_addr || bram_din !== 0) begin
        errs++;
        $display("FAIL send_mux%0d: en=%b we=%b addr=%0d din=%h, want %b/0/%0d/00",
                 k, bram_en, bram_we, bram_addr, bram_din, tx_en, tx_addr);
      end
      tick;
      tx_done = 0;
      checks++;
      if (phase !== 3'd3 || tx_start !== 0) begin
        errs++;
        $display("FAIL send_hold%0d: phase=%0d tx_start=%b, want 3/0", k, phase, tx_start);
      end
    end
    quiet;
    tx_done = 1;
    tick;
    tx_done = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (phase !== 3'd4 || show_i !== 1 || err !== 0) begin
        errs++;
        $display("FAIL done%0d: phase=%0d show=%b err=%b, want 4/1/0", k, phase, show_i, err);
      end
      rx_valid = 1; proc_we = 1; tx_en = 1;
      check_zero_port("done_port");
      tick;
      quiet;
    end
  endtask

  task automatic test_timeout;
    do_start;
    load_image;
    for (int k = 1; k <= int'(TMO); k++) begin
      checks++;
      if (phase !== 3'd2) begin errs++; $display("FAIL proc_wait%0d: phase=%0d want 2", k, phase); end
      tick;
    end
    checks++;
    if (phase !== 3'd5 || err !== 1) begin
      errs++;
      $display("FAIL proc_timeout: phase=%0d err=%b, want 5/1", phase, err);
    end
    check_zero_port("fail_port");
    do_start;
    load_image;
    tick;
    proc_done = 1;
    tick;
    proc_done = 0;
    for (int k = 1; k <= int'(TMO); k++) begin
      tx_done = (k == int'(TMO));
      checks++;
      if (phase !== 3'd3) begin errs++; $display("FAIL send_wait%0d: phase=%0d want 3", k, phase); end
      tick;
    end
    tx_done = 0;
    checks++;
    if (phase !== 3'd5 || err !== 1 || show_i !== 0) begin
      errs++;
      $display("FAIL send_timeout_priority: phase=%0d err=%b show=%b, want 5/1/0", phase, err, show_i);
    end
  endtask

  task automatic test_reset_mid_load;
    do_start;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1; rx_data = 8'($urandom);
      tick;
    end
    rx_valid = 0;
    test_reset;
    do_start;
    rx_valid = 1; rx_data = 8'h3C;
    #1;
    checks++;
    if (bram_we !== 1 || bram_addr !== AW'(0) || bram_din !== 8'h3C) begin
      errs++;
      $display("FAIL restart_addr: we=%b addr=%0d din=%h, want 1/0/3c", bram_we, bram_addr, bram_din);
    end
    tick;
    rx_valid = 0;
  endtask

  initial begin
    test_reset;
    test_load;
    test_ignored;
    test_proc_mux;
    test_send;
    test_timeout;
    test_reset_mid_load;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/img_bram_sequencer.md
IMG_BRAM_SEQUENCER -- requirements
Module: img_bram_sequencer

Interface
REQ-001 Parameter NPIX, default 22500: pixels per image (150x150).
REQ-002 Parameter AW, default 15: BRAM address width.
REQ-003 Parameter DW, default 8: pixel width.
REQ-004 Parameter TMO, default 24'hFFFFFF: watchdog limit in cycles for PROC and SEND.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  begin a load/process/send run.
REQ-008 rx_valid  in  1  received pixel strobe, one cycle per byte.
REQ-009 rx_data  in  DW  received pixel value.
REQ-010 proc_start  out  1  one-cycle pulse: processing engine may begin.
REQ-011 proc_en, proc_we  in  1 each  processing engine BRAM enable/write enable.
REQ-012 proc_addr  in  AW; proc_din  in  DW  processing engine BRAM address/data.
REQ-013 proc_done  in  1  processing engine finished.
REQ-014 tx_start  out  1  one-cycle pulse to the UART image transmitter.
REQ-015 tx_en  in  1; tx_addr  in  AW  transmitter BRAM read port.
REQ-016 tx_done  in  1  transmitter finished the last byte.
REQ-017 bram_en, bram_we  out  1 each; bram_addr  out  AW; bram_din  out  DW  single BRAM port.
REQ-018 phase  out  3  current state encoding.
REQ-019 show_i  out  1  image fully sent and ready to display.
REQ-020 err  out  1  watchdog expired; sticky until start or reset.

Function
REQ-021 States and phase codes SHALL be IDLE=0, LOAD=1, PROC=2, SEND=3, DONE=4, FAIL=5.
REQ-022 IDLE, DONE, FAIL: start=1 SHALL move to LOAD next cycle, clearing pixel counter, watchdog, show_i and err; start in LOAD/PROC/SEND SHALL be ignored.
REQ-023 LOAD: each rx_valid SHALL drive bram_en=1, bram_we=1, bram_addr=pix_cnt, bram_din=rx_data combinationally that cycle, then increment pix_cnt.
REQ-024 LOAD: rx_valid with pix_cnt==NPIX-1 SHALL write that pixel and move to PROC next cycle; no write ever targets an address >= NPIX.
REQ-025 rx_valid outside LOAD SHALL be ignored (no BRAM access, no counter change).
REQ-026 Entry to PROC SHALL assert proc_start for exactly the first PROC cycle.
REQ-027 PROC: bram_en/we/addr/din SHALL equal proc_en/proc_we/proc_addr/proc_din combinationally.
REQ-028 PROC: proc_done SHALL be honoured only from the cycle after proc_start; it moves to SEND next cycle.
REQ-029 Entry to SEND SHALL assert tx_start for exactly the first SEND cycle.
REQ-030 SEND: bram_en=tx_en, bram_addr=tx_addr, bram_we=0 and bram_din=0 regardless of client inputs.
REQ-031 SEND: tx_done, honoured from the cycle after tx_start, SHALL move to DONE; show_i SHALL be 1 registered from DONE entry until start or reset.
REQ-032 In IDLE, DONE and FAIL, bram_en, bram_we, bram_addr and bram_din SHALL be 0.
REQ-033 Ungranted client inputs SHALL never reach the BRAM port (e.g. proc_we during SEND has no effect).
REQ-034 Watchdog SHALL count cycles in PROC and SEND, clearing on each state entry; reaching TMO SHALL move to FAIL and set err, taking priority over a same-cycle done.
REQ-035 pix_cnt SHALL be AW bits wide and never wrap.

Reset
REQ-036 Reset SHALL force IDLE, phase=0, pix_cnt=0, watchdog=0, proc_start=0, tx_start=0, show_i=0, err=0, all bram_* outputs 0, from any state including mid-LOAD/PROC/SEND.

Verification (NPIX=4, TMO=20)
REQ-037 start, then 4 rx_valid bytes 0x11,0x22,0x33,0x44 -> writes to addr 0..3, phase 1->2 the cycle after the 4th, proc_start one cycle.
REQ-038 In PROC, proc_we=1, proc_addr=2, proc_din=0xAA -> bram_we=1, bram_addr=2, bram_din=0xAA the same cycle; rx_valid then -> no write.
REQ-039 proc_done -> tx_start pulse; tx_en=1, tx_addr=3 -> bram_en=1, bram_we=0, bram_addr=3; tx_done -> phase=4, show_i=1 next cycle.
REQ-040 PROC with no proc_done for 20 cycles -> phase=5, err=1; start -> phase=1, err=0.
REQ-041 Reset asserted after 2 LOAD bytes -> phase=0, all outputs 0; a new start restarts writes at addr 0.
REQ-042 start pulsed during PROC, and proc_done asserted in the proc_start cycle -> both ignored, phase stays 2.
